picomips_core: RTL and testbench

Parametrised third-generation picoMIPS processing core. It fetches from an external combinational program ROM and executes a compact accumulator-style instruction set over an N-bit register file. Compared with the previous switch/LED top level, it adds:
- valid/ready streaming input and output ports in place of a handshake switch and a register-mapped port;
- a fractional multiply-immediate instruction;
- a conditional branch;
- a HALT state.

It sits below the board-level wrapper, which ties the streams to switches/LEDs or to a test harness.

---
 rtl/picomips_pkg.sv | 42 ++++
 rtl/picomips_regfile.sv | 45 ++++
 rtl/picomips_core.sv | 153 +++++++++++++++
 tb/tb_picomips_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared types and instruction field layout for the picoMIPS core.
// Field positions are computed from the data width N and register address width R.
package picomips_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_MULI = 3'b011,
    OP_IN   = 3'b100,
    OP_OUT  = 3'b101,
    OP_BNZ  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Instruction layout, MSB first: opcode | rd | rs | imm
  function automatic int instr_width(input int n, input int r);
    return 3 + 2 * r + n;
  endfunction

  function automatic int op_lsb(input int n, input int r);
    return n + 2 * r;
  endfunction

  function automatic int rd_lsb(input int n, input int r);
    return n + r;
  endfunction

  function automatic int rs_lsb(input int n, input int r);
    return n + 0 * r;
  endfunction

  function automatic int imm_lsb(input int n, input int r);
    return 0 * (n + r);
  endfunction

endpackage

// File: rtl/picomips_regfile.sv
// 2^R x N register file: two asynchronous read ports, one synchronous write port.
// Register r0 always reads zero and ignores writes.
module picomips_regfile import picomips_pkg::*; #(
  parameter int N = 8,
  parameter int R = 3
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [R-1:0] ra_addr,
  output logic [N-1:0] ra_data,
  input  logic [R-1:0] rb_addr,
  output logic [N-1:0] rb_data,
  input  logic         we,
  input  logic [R-1:0] wa,
  input  logic [N-1:0] wd
);

  localparam int NREG = 2 ** R;

  logic [N-1:0] regs_q [NREG];
  logic [N-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != R'(0))) begin
      regs_d[wa] = wd;
    end else begin
      regs_d = regs_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {N{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = (ra_addr == R'(0)) ? {N{1'b0}} : regs_q[ra_addr];
  assign rb_data = (rb_addr == R'(0)) ? {N{1'b0}} : regs_q[rb_addr];

endmodule

// File: rtl/picomips_core.sv
// picoMIPS accumulator-style core: PC, RUN/HALT FSM, stream handshakes and ALU/multiplier.
// Executes one instruction per cycle from a combinational ROM unless an IN/OUT stall holds the PC.
module picomips_core import picomips_pkg::*; #(
  parameter int N = 8,
  parameter int R = 3,
  parameter int P = 8
) (
  input  logic               clk,
  input  logic               n_reset,
  output logic [P-1:0]       imem_addr,
  input  logic [3+2*R+N-1:0] imem_data,
  input  logic [N-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N-1:0]       out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted
);

  localparam int OP_LSB  = op_lsb(N, R);
  localparam int RD_LSB  = rd_lsb(N, R);
  localparam int RS_LSB  = rs_lsb(N, R);
  localparam int IMM_LSB = imm_lsb(N, R);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MOST_POS = {1'b0, {(N-1){1'b1}}};

  opcode_t        op_s;
  logic [R-1:0]   rd_addr_s, rs_addr_s;
  logic [N-1:0]   imm_s, rd_val_s, rs_val_s;

  state_t         state_q, state_d;
  logic [P-1:0]   pc_q, pc_d, pc_inc_s;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           rf_we_s;
  logic [N-1:0]   rf_wd_s;

  logic [2*N-1:0] mul_a_s, mul_b_s, prod_s;
  logic [N-1:0]   mul_s;
  logic           unused_ok_s;

  assign op_s      = opcode_t'(imem_data[OP_LSB +: 3]);
  assign rd_addr_s = imem_data[RD_LSB +: R];
  assign rs_addr_s = imem_data[RS_LSB +: R];
  assign imm_s     = imem_data[IMM_LSB +: N];

  picomips_regfile #(.N(N), .R(R)) u_regfile (
    .clk     (clk),
    .n_reset (n_reset),
    .ra_addr (rd_addr_s),
    .ra_data (rd_val_s),
    .rb_addr (rs_addr_s),
    .rb_data (rs_val_s),
    .we      (rf_we_s),
    .wa      (rd_addr_s),
    .wd      (rf_wd_s)
  );

  // Sign-extended operands give the exact signed product in the low 2N bits.
  assign mul_a_s     = {{N{rd_val_s[N-1]}}, rd_val_s};
  assign mul_b_s     = {{N{imm_s[N-1]}}, imm_s};
  assign prod_s      = mul_a_s * mul_b_s;
  assign mul_s       = ((rd_val_s == MOST_NEG) && (imm_s == MOST_NEG)) ? MOST_POS
                                                                        : prod_s[2*N-2:N-1];
  assign unused_ok_s = ^{prod_s[2*N-1], prod_s[N-2:0]};

  assign pc_inc_s = pc_q + P'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_data_d = out_data_q;
    rf_we_s    = 1'b0;
    rf_wd_s    = {N{1'b0}};
    // A pending beat drains on accept even while stalled or halted.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (state_q == ST_RUN) begin
      case (op_s)
        OP_NOP: pc_d = pc_inc_s;
        OP_ADD: begin
          rf_we_s = 1'b1;
          rf_wd_s = rd_val_s + rs_val_s;
          pc_d    = pc_inc_s;
        end
        OP_ADDI: begin
          rf_we_s = 1'b1;
          rf_wd_s = rd_val_s + imm_s;
          pc_d    = pc_inc_s;
        end
        OP_MULI: begin
          rf_we_s = 1'b1;
          rf_wd_s = mul_s;
          pc_d    = pc_inc_s;
        end
        OP_IN: begin
          if (in_valid) begin
            rf_we_s = 1'b1;
            rf_wd_s = in_data;
            pc_d    = pc_inc_s;
          end else begin
            pc_d = pc_q;
          end
        end
        OP_OUT: begin
          if (!out_valid_q || out_ready) begin
            out_data_d  = rd_val_s;
            out_valid_d = 1'b1;
            pc_d        = pc_inc_s;
          end else begin
            pc_d = pc_q;
          end
        end
        OP_BNZ: begin
          if (rd_val_s != {N{1'b0}}) begin
            pc_d = imm_s[P-1:0];
          end else begin
            pc_d = pc_inc_s;
          end
        end
        OP_HALT: state_d = ST_HALT;
        default: pc_d = pc_q;
      endcase
    end else begin
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_RUN;
      pc_q        <= {P{1'b0}};
      out_data_q  <= {N{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign in_ready  = (state_q == ST_RUN) && (op_s == OP_IN);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_picomips_core.sv
// Scoreboard bench for picomips_core (N=8, R=3, P=4): directed programs plus random
// straight-line programs checked against an instruction-level reference model.
module tb_picomips_core;

  localparam int N  = 8;
  localparam int R  = 3;
  localparam int P  = 4;
  localparam int IW = 3 + 2 * R + N;

  localparam logic [2:0] O_NOP  = 3'd0;
  localparam logic [2:0] O_ADD  = 3'd1;
  localparam logic [2:0] O_ADDI = 3'd2;
  localparam logic [2:0] O_MULI = 3'd3;
  localparam logic [2:0] O_IN   = 3'd4;
  localparam logic [2:0] O_OUT  = 3'd5;
  localparam logic [2:0] O_BNZ  = 3'd6;
  localparam logic [2:0] O_HALT = 3'd7;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [P-1:0]  imem_addr;
  logic [IW-1:0] imem_data;
  logic [N-1:0]  in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          halted;

  logic [IW-1:0] rom [16];
  logic [7:0]    exp_q [$];
  logic [7:0]    in_list [$];
  logic [7:0]    mon_exp;
  int            checks = 0;
  int            passes = 0;

  picomips_core #(.N(N), .R(R), .P(P)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [IW-1:0] enc(input logic [2:0] op, input int rd, input int rs, input int imm);
    return {op, rd[2:0], rs[2:0], imm[7:0]};
  endfunction

  // Monitor: a beat is consumed on the edge following a valid&&ready half-cycle.
  always @(negedge clk) begin
    if (n_reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got %0h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_beat", 32'(out_data), 32'(mon_exp));
      end
    end
  end

  // Instruction-level model: walks the ROM, collecting the OUT values in order.
  task automatic model();
    int regs [8];
    int pc = 0, k = 0, steps = 0, op, rd, rs, imm, a, sa, sb, v;
    bit stop = 0;
    logic [IW-1:0] ins;
    foreach (regs[i]) regs[i] = 0;
    while (!stop && steps < 200) begin
      ins = rom[pc];
      op = int'(ins[16:14]); rd = int'(ins[13:11]); rs = int'(ins[10:8]); imm = int'(ins[7:0]);
      a = regs[rd];
      v = -1;
      case (op)
        1: v = (a + regs[rs]) % 256;
        2: v = (a + imm) % 256;
        3: begin
          sa = (a >= 128) ? a - 256 : a;
          sb = (imm >= 128) ? imm - 256 : imm;
          if (sa == -128 && sb == -128) v = 127;
          else v = ((sa * sb) >>> 7) & 255;
        end
        4: begin v = int'(in_list[k]); k++; end
        5: exp_q.push_back(a[7:0]);
        7: stop = 1;
        default: ;
      endcase
      if (v >= 0 && rd != 0) regs[rd] = v;
      if (op == 6 && a != 0) pc = imm % 16;
      else if (op != 7) pc = (pc + 1) % 16;
      steps++;
    end
  endtask

  task automatic rst_assert();
    @(negedge clk);
    #2;
    n_reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    #1;
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    exp_q.delete();
    in_list.delete();
    for (int i = 0; i < 16; i++) rom[i] = enc(O_HALT, 0, 0, 0);
  endtask

  task automatic rst_release();
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  // rmode: 0 random / 1 always / 2 toggling out_ready. vmode: 0 random / 1 always / 2 low for 3 IN-stall cycles.
  task automatic run(input int rmode, input int vmode, input bit chk_b2b, input int max_cycles);
    int idx = 0, cyc = 0, stalls = 0;
    bit xfer = 0, done = 0;
    logic [P-1:0] frz;
    while (!done && cyc < max_cycles) begin
      @(posedge clk);
      #1;
      if (xfer) idx++;
      case (rmode)
        0: out_ready = 1'($urandom_range(0, 1));
        1: out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
      case (vmode)
        0: in_valid = 1'($urandom_range(0, 1));
        1: in_valid = 1'b1;
        default: in_valid = (stalls >= 3);
      endcase
      in_data = (idx < in_list.size()) ? in_list[idx] : 8'h00;
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (vmode == 2 && in_ready && !in_valid) begin
        check("in_stall_pc", 32'(imem_addr), 32'd0);
        stalls++;
      end
      if (chk_b2b && (imem_addr == 4'd3 || imem_addr == 4'd4))
        check("b2b_valid", 32'(out_valid), 32'd1);
      if (halted && exp_q.size() == 0 && !out_valid) done = 1;
      cyc++;
    end
    if (!done) begin
      checks++;
      $display("FAIL run_timeout: got %0d beats outstanding halted=%0b expected 0 and halted", exp_q.size(), halted);
    end else begin
      frz = imem_addr;
      repeat (3) @(negedge clk);
      check("halt_pc_frozen", 32'(imem_addr), 32'(frz));
      check("halt_state", 32'(halted), 32'd1);
      check("drained", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    // Add/subtract to 0xFE then a single beat.
    rst_assert();
    rom[0] = enc(O_ADDI, 1, 0, 5);
    rom[1] = enc(O_ADDI, 1, 0, -7);
    rom[2] = enc(O_OUT, 1, 0, 0);
    exp_q.push_back(8'hFE);
    rst_release();
    run(1, 1, 0, 50);

    // IN stall for three cycles, then 0x40 * 0.5.
    rst_assert();
    rom[0] = enc(O_IN, 2, 0, 0);
    rom[1] = enc(O_MULI, 2, 0, 8'h40);
    rom[2] = enc(O_OUT, 2, 0, 0);
    in_list.push_back(8'h40);
    exp_q.push_back(8'h20);
    rst_release();
    run(1, 2, 0, 50);

    // Fractional multiply saturation and most-negative times most-positive.
    rst_assert();
    rom[0] = enc(O_ADDI, 3, 0, 8'h80);
    rom[1] = enc(O_MULI, 3, 0, 8'h80);
    rom[2] = enc(O_OUT, 3, 0, 0);
    rom[3] = enc(O_ADDI, 4, 0, 8'h80);
    rom[4] = enc(O_MULI, 4, 0, 8'h7F);
    rom[5] = enc(O_OUT, 4, 0, 0);
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h81);
    rst_release();
    run(0, 1, 0, 80);

    // Countdown loop with toggling consumer.
    rst_assert();
    rom[0] = enc(O_ADDI, 1, 0, 3);
    rom[1] = enc(O_OUT, 1, 0, 0);
    rom[2] = enc(O_ADDI, 1, 0, -1);
    rom[3] = enc(O_BNZ, 1, 0, 1);
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd1);
    rst_release();
    run(2, 1, 0, 100);
    check("countdown_halt_pc", 32'(imem_addr), 32'd4);

    // Back-to-back OUT, then r0 writes read back as zero.
    rst_assert();
    rom[0] = enc(O_ADDI, 1, 0, 9);
    rom[1] = enc(O_ADDI, 2, 0, 4);
    rom[2] = enc(O_OUT, 1, 0, 0);
    rom[3] = enc(O_OUT, 2, 0, 0);
    rom[4] = enc(O_ADDI, 0, 0, 5);
    rom[5] = enc(O_ADD, 0, 1, 0);
    rom[6] = enc(O_OUT, 0, 0, 0);
    exp_q.push_back(8'd9);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd0);
    rst_release();
    run(1, 1, 1, 50);

    // Reset in the middle of an IN stall.
    rst_assert();
    rom[0] = enc(O_ADDI, 1, 0, 1);
    rom[1] = enc(O_IN, 2, 0, 0);
    rst_release();
    repeat (3) @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd1);
    check("stall_pc_hold", 32'(imem_addr), 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check("midstall_in_ready", 32'(in_ready), 32'd0);
    check("midstall_pc", 32'(imem_addr), 32'd0);

    // PC wraps 15 -> 0 over a NOP-only program.
    rst_assert();
    for (int i = 0; i < 16; i++) rom[i] = enc(O_NOP, 0, 0, 0);
    rst_release();
    for (int k = 0; k < 20; k++) begin
      check("pc_wrap", 32'(imem_addr), 32'(k % 16));
      @(negedge clk);
    end

    // Random forward-only programs against the reference model.
    for (int t = 0; t < 12; t++) begin
      rst_assert();
      for (int i = 0; i < 15; i++) begin
        int op, imm;
        op  = int'($urandom_range(0, 6));
        imm = int'($urandom_range(0, 255));
        if (op == 6) imm = (imm & 8'hF0) | int'($urandom_range(i + 1, 15));
        rom[i] = enc(3'(op), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm);
      end
      for (int i = 0; i < 16; i++) in_list.push_back(8'($urandom_range(0, 255)));
      model();
      rst_release();
      run(0, 0, 0, 600);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
